// File: rtl/signed_pow2_div_seq_pkg.sv
// Shared types and helpers for the sequential signed divide-by-2^k unit.
package signed_div_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    OUT   = 2'd2
  } div_state_e;

  // Number of rising edges, counting the acceptance edge, until down_valid is seen high.
  function automatic int unsigned div_latency(input int unsigned k, input int unsigned step);
    if (k == 0) return 1;
    return (k + step - 1) / step + 1;
  endfunction

endpackage

// File: rtl/signed_pow2_div_seq_sra.sv
// Combinational arithmetic right shift by 0..STEP bits, reporting whether any dropped bit was set.
module sra_step #(
  parameter int W    = 8,
  parameter int STEP = 1,
  parameter int SW   = $clog2(W)
) (
  input  logic [W-1:0]  i_value,
  input  logic [SW-1:0] i_n,
  output logic [W-1:0]  o_value,
  output logic          o_dropped
);

  logic [W-1:0] w_cand [STEP+1];
  logic         w_drop [STEP+1];

  assign w_cand[0] = i_value;
  assign w_drop[0] = 1'b0;

  for (genvar i = 1; i <= STEP; i++) begin : g_cand
    assign w_cand[i] = {{i{i_value[W-1]}}, i_value[W-1:i]};
    assign w_drop[i] = |i_value[i-1:0];
  end

  always_comb begin
    o_value   = i_value;
    o_dropped = 1'b0;
    for (int i = 1; i <= STEP; i++) begin
      if (i_n == SW'(i)) begin
        o_value   = w_cand[i];
        o_dropped = w_drop[i];
      end
    end
  end

endmodule

// File: rtl/signed_pow2_div_seq.sv
// Multi-cycle signed divide by 2^k with round-toward-zero, shifting at most STEP bits per cycle.
module signed_pow2_div_seq
  import signed_div_pkg::*;
#(
  parameter int W    = 8,
  parameter int SW   = $clog2(W),
  parameter int STEP = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          up_valid,
  output logic          up_ready,
  input  logic [W-1:0]  up_data,
  input  logic [SW-1:0] up_shift,
  output logic          down_valid,
  input  logic          down_ready,
  output logic [W-1:0]  down_quot,
  output logic          down_exact
);

  localparam logic [SW-1:0] K_MAX  = SW'(W - 1);
  localparam logic [SW-1:0] STEP_N = SW'(STEP);

  div_state_e          r_state, w_state_nxt;
  logic signed [W-1:0] r_acc;
  logic [SW-1:0]       r_cnt;
  logic                r_sticky;
  logic [W-1:0]        r_quot;
  logic                r_exact;

  logic [SW-1:0] w_shift_ld, w_n, w_cnt_nxt;
  logic [W-1:0]  w_shifted;
  logic          w_dropped, w_sticky_nxt, w_accept, w_last;

  // A raw arithmetic shift floors; negative values with lost bits need +1 to truncate.
  function automatic logic [W-1:0] round_tz(input logic [W-1:0] v, input logic neg,
                                            input logic st);
    return v + {{(W-1){1'b0}}, neg & st};
  endfunction

  if ((2 ** SW) > W) begin : g_clamp
    assign w_shift_ld = (up_shift > K_MAX) ? K_MAX : up_shift;
  end else begin : g_noclamp
    assign w_shift_ld = up_shift;
  end

  assign up_ready     = (r_state == IDLE);
  assign down_valid   = (r_state == OUT);
  assign down_quot    = r_quot;
  assign down_exact   = r_exact;
  assign w_accept     = up_valid && up_ready;
  assign w_n          = (r_cnt < STEP_N) ? r_cnt : STEP_N;
  assign w_cnt_nxt    = r_cnt - w_n;
  assign w_sticky_nxt = r_sticky | w_dropped;
  assign w_last       = (w_cnt_nxt == '0);

  sra_step #(
    .W   (W),
    .STEP(STEP),
    .SW  (SW)
  ) u_sra (
    .i_value  (r_acc),
    .i_n      (w_n),
    .o_value  (w_shifted),
    .o_dropped(w_dropped)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_accept) w_state_nxt = (w_shift_ld == '0) ? OUT : SHIFT;
      SHIFT:   if (w_last) w_state_nxt = OUT;
      OUT:     if (down_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc    <= '0;
      r_cnt    <= '0;
      r_sticky <= 1'b0;
      r_quot   <= '0;
      r_exact  <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_acc    <= up_data;
            r_cnt    <= w_shift_ld;
            r_sticky <= 1'b0;
            if (w_shift_ld == '0) begin
              r_quot  <= up_data;
              r_exact <= 1'b1;
            end
          end
        end
        SHIFT: begin
          r_acc    <= w_shifted;
          r_cnt    <= w_cnt_nxt;
          r_sticky <= w_sticky_nxt;
          if (w_last) begin
            r_quot  <= round_tz(w_shifted, r_acc[W-1], w_sticky_nxt);
            r_exact <= ~w_sticky_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
